e1_bd_ctrl_mc: RTL and testbench

// Multi-channel Wishbone CSR and buffer-descriptor (BD) controller for NCH E1 links.

---
 rtl/e1_bd_ctrl_mc.sv | 273 +++++++++++++++++++++++++++
 tb/tb_e1_bd_ctrl_mc.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e1_bd_ctrl_mc.sv
// e1_bd_ctrl_mc: Wishbone CSR and buffer-descriptor controller for NCH E1 links.
// Ports: clk/rst (async, active-high); bus_* CPU slave port with a one-cycle ack;
//   bdrx_*/bdtx_* descriptor handshakes to the RX/TX cores;
//   rx_*/tx_* per-channel control outputs; irq is the registered OR of enabled pending bits.

module e1_bd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [3:0]   level,
    output logic         empty,
    output logic         full,
    output logic         push_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] cnt;
    logic          pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == LW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push & (~full | pop_ok);
    // Empty reads as zero so a pop on an empty FIFO returns 0.
    assign rdata   = empty ? '0 : mem[rptr];
    assign level   = 4'(cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop_ok) rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module e1_bd_ctrl_mc #(
    parameter int NCH   = 2,
    parameter int MFW   = 7,
    parameter int DEPTH = 4,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHW+2:0]       bus_addr,
    input  logic [15:0]          bus_wdata,
    output logic [15:0]          bus_rdata,
    input  logic                 bus_cyc,
    input  logic                 bus_we,
    output logic                 bus_ack,
    output logic [NCH*MFW-1:0]   bdrx_mf,
    output logic [NCH-1:0]       bdrx_valid,
    input  logic [NCH-1:0]       bdrx_done,
    input  logic [2*NCH-1:0]     bdrx_crc_e,
    input  logic [NCH-1:0]       bdrx_miss,
    output logic [NCH*MFW-1:0]   bdtx_mf,
    output logic [2*NCH-1:0]     bdtx_crc_e,
    output logic [NCH-1:0]       bdtx_valid,
    input  logic [NCH-1:0]       bdtx_done,
    input  logic [NCH-1:0]       bdtx_miss,
    input  logic [NCH-1:0]       rx_aligned,
    output logic [NCH-1:0]       rx_enable,
    output logic [2*NCH-1:0]     rx_mode,
    output logic [NCH-1:0]       tx_enable,
    output logic [2*NCH-1:0]     tx_mode,
    output logic [NCH-1:0]       tx_time_src,
    output logic [NCH-1:0]       tx_alarm,
    output logic [NCH-1:0]       tx_loopback,
    output logic                 irq
);
    localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

    logic           ack;
    logic [CHW-1:0] ch_sel;
    logic [2:0]     reg_sel;
    logic           ch_ok;
    logic           access;
    logic [15:0]    rd_word [NCH];
    logic [NCH-1:0] irq_hit;

    assign ch_sel  = bus_addr[CHW+2:3];
    assign reg_sel = bus_addr[2:0];
    assign ch_ok   = ({1'b0, ch_sel} < NCH_L);
    // Side effects fire only in the ack cycle, so each access acts once.
    assign access  = ack & bus_cyc & ch_ok;
    assign bus_ack = ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ack <= 1'b0;
        else     ack <= bus_cyc & ~ack;
    end

    always_comb begin
        bus_rdata = '0;
        if (ack && ch_ok) bus_rdata = rd_word[ch_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= |irq_hit;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic           wr;
        logic           rd;
        logic [MFW-1:0] rxin_q;
        logic [MFW+1:0] rxout_q;
        logic [MFW+1:0] txin_q;
        logic [MFW-1:0] txout_q;
        logic [3:0]     rxin_lvl, rxout_lvl, txin_lvl, txout_lvl;
        logic           rxin_empty, rxin_full, rxout_empty, rxout_full;
        logic           txin_empty, txin_full, txout_empty, txout_full;
        logic           rxin_pok, rxout_pok, txin_pok, txout_pok;
        logic           unused_pok;
        logic           rx_move, tx_move, rx_lost;
        logic           clr_rx, clr_tx;
        logic           rx_en, tx_en, tsrc, alarm, lb;
        logic [1:0]     rx_md, tx_md;
        logic [3:0]     irq_en;
        logic [3:0]     pending;
        logic           ovf, unf;
        logic [7:0]     rx_cnt, tx_cnt, rx_cnt_n, tx_cnt_n;
        logic [1:0]     e_auto, e_auto_n;
        logic [15:0]    word;

        assign wr = access & bus_we & (ch_sel == CHW'(c));
        assign rd = access & ~bus_we & (ch_sel == CHW'(c));

        assign rx_move = bdrx_done[c] & ~rxin_empty;
        assign tx_move = bdtx_done[c] & ~txin_empty;
        assign rx_lost = rx_move & ~rxout_pok;
        assign unused_pok = rxin_pok ^ txin_pok ^ txout_pok;

        e1_bd_fifo #(.W(MFW), .DEPTH(DEPTH)) u_rxin (
            .clk(clk), .rst(rst),
            .push(wr && reg_sel == 3'd1), .pop(rx_move),
            .wdata(bus_wdata[MFW-1:0]), .rdata(rxin_q),
            .level(rxin_lvl), .empty(rxin_empty), .full(rxin_full),
            .push_ok(rxin_pok)
        );

        e1_bd_fifo #(.W(MFW+2), .DEPTH(DEPTH)) u_rxout (
            .clk(clk), .rst(rst),
            .push(rx_move), .pop(rd && reg_sel == 3'd1),
            .wdata({bdrx_crc_e[2*c +: 2], rxin_q}), .rdata(rxout_q),
            .level(rxout_lvl), .empty(rxout_empty), .full(rxout_full),
            .push_ok(rxout_pok)
        );

        e1_bd_fifo #(.W(MFW+2), .DEPTH(DEPTH)) u_txin (
            .clk(clk), .rst(rst),
            .push(wr && reg_sel == 3'd3), .pop(tx_move),
            .wdata({bus_wdata[14:13], bus_wdata[MFW-1:0]}), .rdata(txin_q),
            .level(txin_lvl), .empty(txin_empty), .full(txin_full),
            .push_ok(txin_pok)
        );

        e1_bd_fifo #(.W(MFW), .DEPTH(DEPTH)) u_txout (
            .clk(clk), .rst(rst),
            .push(tx_move), .pop(rd && reg_sel == 3'd3),
            .wdata(txin_q[MFW-1:0]), .rdata(txout_q),
            .level(txout_lvl), .empty(txout_empty), .full(txout_full),
            .push_ok(txout_pok)
        );

        assign clr_rx = wr & (reg_sel == 3'd0) & bus_wdata[12];
        assign clr_tx = wr & (reg_sel == 3'd2) & bus_wdata[12];

        // Clear is applied first so a coincident miss leaves a count of 1.
        always_comb begin
            rx_cnt_n = clr_rx ? 8'd0 : rx_cnt;
            if (bdrx_miss[c] && rx_cnt_n != 8'hFF) rx_cnt_n = rx_cnt_n + 8'd1;
            tx_cnt_n = clr_tx ? 8'd0 : tx_cnt;
            if (bdtx_miss[c] && tx_cnt_n != 8'hFF) tx_cnt_n = tx_cnt_n + 8'd1;
            e_auto_n = (bdtx_done[c] ? {2{rx_aligned[c]}} : e_auto)
                     & (bdrx_done[c] ? bdrx_crc_e[2*c +: 2] : 2'b11);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rx_en  <= 1'b0;
                rx_md  <= 2'b00;
                tx_en  <= 1'b0;
                tx_md  <= 2'b00;
                tsrc   <= 1'b0;
                alarm  <= 1'b0;
                lb     <= 1'b0;
                irq_en <= 4'h0;
                ovf    <= 1'b0;
                unf    <= 1'b0;
                rx_cnt <= 8'd0;
                tx_cnt <= 8'd0;
                e_auto <= 2'b11;
            end else begin
                if (wr && reg_sel == 3'd0) begin
                    rx_en <= bus_wdata[0];
                    rx_md <= bus_wdata[2:1];
                end
                if (wr && reg_sel == 3'd2) begin
                    tx_en <= bus_wdata[0];
                    tx_md <= bus_wdata[2:1];
                    tsrc  <= bus_wdata[3];
                    alarm <= bus_wdata[4];
                    lb    <= bus_wdata[5];
                end
                if (wr && reg_sel == 3'd4) irq_en <= bus_wdata[3:0];
                ovf    <= (ovf & ~clr_rx) | rx_lost | bdrx_miss[c];
                unf    <= (unf & ~clr_tx) | bdtx_miss[c];
                rx_cnt <= rx_cnt_n;
                tx_cnt <= tx_cnt_n;
                e_auto <= e_auto_n;
            end
        end

        assign pending    = {unf, ovf, ~txout_empty, ~rxout_empty};
        assign irq_hit[c] = |(pending & irq_en);

        always_comb begin
            word = '0;
            case (reg_sel)
                3'd0: word = {3'b0, ovf, rxout_full, rxout_empty,
                              rxin_full, rxin_empty, 6'b0, rx_aligned[c], rx_en};
                3'd1: word = {~rxout_empty, rxout_q[MFW+1:MFW],
                              {(13-MFW){1'b0}}, rxout_q[MFW-1:0]};
                3'd2: word = {3'b0, unf, txout_full, txout_empty,
                              txin_full, txin_empty, 7'b0, tx_en};
                3'd3: word = {~txout_empty, {(15-MFW){1'b0}}, txout_q};
                3'd4: word = {12'b0, irq_en};
                3'd5: word = {12'b0, pending};
                3'd6: word = {txout_lvl, txin_lvl, rxout_lvl, rxin_lvl};
                3'd7: word = {tx_cnt, rx_cnt};
                default: word = '0;
            endcase
        end
        assign rd_word[c] = word;

        assign bdrx_mf[c*MFW +: MFW]  = rxin_q;
        assign bdrx_valid[c]          = ~rxin_empty;
        assign bdtx_mf[c*MFW +: MFW]  = txin_q[MFW-1:0];
        assign bdtx_valid[c]          = ~txin_empty;
        assign bdtx_crc_e[2*c +: 2]   = (tx_md == 2'b11) ? e_auto : txin_q[MFW+1:MFW];
        assign rx_enable[c]           = rx_en;
        assign rx_mode[2*c +: 2]      = rx_md;
        assign tx_enable[c]           = tx_en;
        assign tx_mode[2*c +: 2]      = tx_md;
        assign tx_time_src[c]         = tsrc;
        assign tx_alarm[c]            = alarm;
        assign tx_loopback[c]         = lb;
    end
endmodule

// File: tb/tb_e1_bd_ctrl_mc.sv
// tb_e1_bd_ctrl_mc: self-checking bench for e1_bd_ctrl_mc (NCH=2, MFW=7, DEPTH=4).
// Ports: none; drives the DUT bus and core handshakes, checks reads against a queue.

module tb_e1_bd_ctrl_mc;
    localparam int NCH = 2;
    localparam int MFW = 7;
    localparam int DEPTH = 4;
    localparam int CHW = 1;
    localparam int AW = CHW + 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [AW-1:0]      bus_addr = '0;
    logic [15:0]        bus_wdata = '0;
    logic [15:0]        bus_rdata;
    logic               bus_cyc = 1'b0;
    logic               bus_we = 1'b0;
    logic               bus_ack;
    logic [NCH*MFW-1:0] bdrx_mf;
    logic [NCH-1:0]     bdrx_valid;
    logic [NCH-1:0]     bdrx_done = '0;
    logic [2*NCH-1:0]   bdrx_crc_e = '0;
    logic [NCH-1:0]     bdrx_miss = '0;
    logic [NCH*MFW-1:0] bdtx_mf;
    logic [2*NCH-1:0]   bdtx_crc_e;
    logic [NCH-1:0]     bdtx_valid;
    logic [NCH-1:0]     bdtx_done = '0;
    logic [NCH-1:0]     bdtx_miss = '0;
    logic [NCH-1:0]     rx_aligned = '0;
    logic [NCH-1:0]     rx_enable;
    logic [2*NCH-1:0]   rx_mode;
    logic [NCH-1:0]     tx_enable;
    logic [2*NCH-1:0]   tx_mode;
    logic [NCH-1:0]     tx_time_src;
    logic [NCH-1:0]     tx_alarm;
    logic [NCH-1:0]     tx_loopback;
    logic               irq;

    int errors = 0;
    int checks = 0;
    logic [15:0]   exp_q [$];
    logic [AW-1:0] adr_q [$];
    logic [15:0]   rd;
    logic [15:0]   exp;

    always #5 clk = ~clk;

    e1_bd_ctrl_mc #(.NCH(NCH), .MFW(MFW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_ack(bus_ack),
        .bdrx_mf(bdrx_mf), .bdrx_valid(bdrx_valid), .bdrx_done(bdrx_done),
        .bdrx_crc_e(bdrx_crc_e), .bdrx_miss(bdrx_miss),
        .bdtx_mf(bdtx_mf), .bdtx_crc_e(bdtx_crc_e), .bdtx_valid(bdtx_valid),
        .bdtx_done(bdtx_done), .bdtx_miss(bdtx_miss),
        .rx_aligned(rx_aligned), .rx_enable(rx_enable), .rx_mode(rx_mode),
        .tx_enable(tx_enable), .tx_mode(tx_mode), .tx_time_src(tx_time_src),
        .tx_alarm(tx_alarm), .tx_loopback(tx_loopback), .irq(irq)
    );

    function automatic logic [AW-1:0] ad(input int ch, input int r);
        return AW'(ch * 8 + r);
    endfunction

    task automatic bus_read(input logic [AW-1:0] a, output logic [15:0] d);
        int n = 0;
        bus_addr = a; bus_we = 1'b0; bus_cyc = 1'b1;
        @(negedge clk);
        while (!bus_ack && n < 8) begin @(negedge clk); n++; end
        if (!bus_ack) begin
            checks++; errors++;
            $display("FAIL read_ack_timeout got=0 need=1");
        end
        d = bus_rdata;
        @(negedge clk);
        bus_cyc = 1'b0;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [15:0] d);
        int n = 0;
        bus_addr = a; bus_wdata = d; bus_we = 1'b1; bus_cyc = 1'b1;
        @(negedge clk);
        while (!bus_ack && n < 8) begin @(negedge clk); n++; end
        if (!bus_ack) begin
            checks++; errors++;
            $display("FAIL write_ack_timeout got=0 need=1");
        end
        @(negedge clk);
        bus_cyc = 1'b0; bus_we = 1'b0;
    endtask

    task automatic pulse(input logic [NCH-1:0] rxd, input logic [NCH-1:0] txd,
                         input logic [NCH-1:0] rxm, input logic [NCH-1:0] txm,
                         input logic [2*NCH-1:0] crc);
        bdrx_done = rxd; bdtx_done = txd; bdrx_miss = rxm; bdtx_miss = txm;
        bdrx_crc_e = crc;
        @(negedge clk);
        bdrx_done = '0; bdtx_done = '0; bdrx_miss = '0; bdtx_miss = '0;
        bdrx_crc_e = '0;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        repeat (2) @(negedge clk);
        outs = {bdrx_mf, bdrx_valid, bdtx_mf, bdtx_crc_e, bdtx_valid, rx_enable,
                rx_mode, tx_enable, tx_mode, tx_time_src, tx_alarm, tx_loopback,
                irq, bus_ack, bus_rdata};
        checks++;
        if (outs !== 64'd0) begin
            errors++; $display("FAIL reset_outputs got=%h need=0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        bus_addr = ad(0, 0); bus_we = 1'b0; bus_cyc = 1'b1;
        exp_q.push_back(16'h0500);
        checks++;
        if (bus_ack !== 1'b0) begin
            errors++; $display("FAIL ack_early got=%b need=0", bus_ack);
        end
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b1) begin
            errors++; $display("FAIL ack_rise got=%b need=1", bus_ack);
        end
        rd = bus_rdata;
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin
            errors++; $display("FAIL reset_r0 got=%h need=%h", rd, exp);
        end
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0) begin
            errors++; $display("FAIL ack_width got=%b need=0", bus_ack);
        end
        bus_cyc = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_rdata !== 16'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL idle_rdata_irq got=%h/%b need=0/0", bus_rdata, irq);
        end
    endtask

    task automatic test_rx_fifo();
        for (int i = 1; i <= DEPTH + 1; i++) bus_write(ad(1, 1), 16'(i));
        checks++;
        if (bdrx_valid !== 2'b10 || bdrx_mf[2*MFW-1:MFW] !== 7'd1) begin
            errors++;
            $display("FAIL rx_head got=%b/%h need=10/01", bdrx_valid, bdrx_mf[2*MFW-1:MFW]);
        end
        adr_q.push_back(ad(1, 6)); exp_q.push_back(16'h0004);
        adr_q.push_back(ad(1, 0)); exp_q.push_back(16'h0600);
        while (adr_q.size() > 0) begin
            bus_read(adr_q.pop_front(), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL rx_fill got=%h need=%h", rd, exp);
            end
        end
        repeat (4) pulse(2'b10, 2'b00, 2'b00, 2'b00, 4'b1000);
        adr_q.push_back(ad(1, 6)); exp_q.push_back(16'h0040);
        adr_q.push_back(ad(1, 0)); exp_q.push_back(16'h0900);
        for (int i = 1; i <= DEPTH; i++) begin
            adr_q.push_back(ad(1, 1)); exp_q.push_back(16'hC000 | 16'(i));
        end
        adr_q.push_back(ad(1, 1)); exp_q.push_back(16'h0000);
        adr_q.push_back(ad(1, 6)); exp_q.push_back(16'h0000);
        while (adr_q.size() > 0) begin
            bus_read(adr_q.pop_front(), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL rx_drain got=%h need=%h", rd, exp);
            end
        end
        pulse(2'b10, 2'b00, 2'b00, 2'b00, 4'b1000);
        adr_q.push_back(ad(1, 6)); exp_q.push_back(16'h0000);
        adr_q.push_back(ad(1, 0)); exp_q.push_back(16'h0500);
        while (adr_q.size() > 0) begin
            bus_read(adr_q.pop_front(), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL rx_done_empty got=%h need=%h", rd, exp);
            end
        end
    endtask

    task automatic test_miss();
        repeat (300) pulse(2'b00, 2'b00, 2'b01, 2'b00, 4'b0);
        adr_q.push_back(ad(0, 7)); exp_q.push_back(16'h00FF);
        adr_q.push_back(ad(0, 0)); exp_q.push_back(16'h1500);
        while (adr_q.size() > 0) begin
            bus_read(adr_q.pop_front(), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL miss_sat got=%h need=%h", rd, exp);
            end
        end
        bus_write(ad(0, 0), 16'h1000);
        repeat (3) pulse(2'b00, 2'b00, 2'b01, 2'b00, 4'b0);
        bus_read(ad(0, 7), rd);
        checks++;
        if (rd !== 16'h0003) begin
            errors++; $display("FAIL miss_after_clear got=%h need=0003", rd);
        end
        bus_addr = ad(0, 0); bus_wdata = 16'h1000; bus_we = 1'b1; bus_cyc = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b1) begin
            errors++; $display("FAIL clr_ack got=%b need=1", bus_ack);
        end
        bdrx_miss = 2'b01;
        @(negedge clk);
        bdrx_miss = 2'b00; bus_cyc = 1'b0; bus_we = 1'b0;
        repeat (2) pulse(2'b00, 2'b00, 2'b00, 2'b01, 4'b0);
        adr_q.push_back(ad(0, 7)); exp_q.push_back(16'h0201);
        adr_q.push_back(ad(0, 0)); exp_q.push_back(16'h1500);
        adr_q.push_back(ad(0, 2)); exp_q.push_back(16'h1500);
        while (adr_q.size() > 0) begin
            bus_read(adr_q.pop_front(), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL miss_clr_race got=%h need=%h", rd, exp);
            end
        end
    endtask

    task automatic test_ebit();
        logic [1:0] want [5];
        want[0] = 2'b11; want[1] = 2'b01; want[2] = 2'b11;
        want[3] = 2'b01; want[4] = 2'b00;
        bus_write(ad(0, 2), 16'h0006);
        rx_aligned = 2'b01;
        checks++;
        if (bdtx_crc_e[1:0] !== 2'b11 || tx_mode !== 4'b0011) begin
            errors++; $display("FAIL ebit_init got=%b/%b need=11/0011", bdtx_crc_e[1:0], tx_mode);
        end
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: pulse(2'b00, 2'b01, 2'b00, 2'b00, 4'b0000);
                1: pulse(2'b01, 2'b00, 2'b00, 2'b00, 4'b0001);
                2: pulse(2'b00, 2'b01, 2'b00, 2'b00, 4'b0000);
                3: pulse(2'b01, 2'b01, 2'b00, 2'b00, 4'b0001);
                default: begin
                    rx_aligned = 2'b00;
                    pulse(2'b00, 2'b01, 2'b00, 2'b00, 4'b0000);
                end
            endcase
            checks++;
            if (bdtx_crc_e[1:0] !== want[k]) begin
                errors++;
                $display("FAIL ebit_step%0d got=%b need=%b", k, bdtx_crc_e[1:0], want[k]);
            end
        end
        bus_write(ad(0, 2), 16'h0000);
        bus_write(ad(0, 3), 16'h4005);
        checks++;
        if (bdtx_crc_e[1:0] !== 2'b10 || bdtx_mf[MFW-1:0] !== 7'd5 || bdtx_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL tx_head got=%b/%h/%b need=10/05/1",
                     bdtx_crc_e[1:0], bdtx_mf[MFW-1:0], bdtx_valid[0]);
        end
        pulse(2'b00, 2'b01, 2'b00, 2'b00, 4'b0);
        adr_q.push_back(ad(0, 3)); exp_q.push_back(16'h8005);
        adr_q.push_back(ad(0, 3)); exp_q.push_back(16'h0000);
        while (adr_q.size() > 0) begin
            bus_read(adr_q.pop_front(), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL tx_out got=%h need=%h", rd, exp);
            end
        end
    endtask

    task automatic test_irq();
        bus_write(ad(1, 4), 16'h0001);
        bus_write(ad(0, 1), 16'h0007);
        pulse(2'b01, 2'b00, 2'b00, 2'b00, 4'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_masked got=%b need=0", irq);
        end
        bus_read(ad(0, 5), rd);
        checks++;
        if (rd !== 16'h000D) begin
            errors++; $display("FAIL pending_ch0 got=%h need=000d", rd);
        end
        bus_write(ad(1, 1), 16'h0003);
        pulse(2'b10, 2'b00, 2'b00, 2'b00, 4'b0);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_latency got=%b need=0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_rise got=%b need=1", irq);
        end
        exp_q.push_back(16'h8003);
        bus_read(ad(1, 1), rd);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || irq !== 1'b1) begin
            errors++; $display("FAIL irq_pop got=%h/%b need=%h/1", rd, irq, exp);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_fall got=%b need=0", irq);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) bus_write(ad(1, 1), 16'(i));
        pulse(2'b10, 2'b00, 2'b00, 2'b00, 4'b0);
        repeat (2) @(negedge clk);
        bus_addr = ad(1, 6); bus_we = 1'b0; bus_cyc = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b1 || irq !== 1'b1 || bus_rdata !== 16'h0012) begin
            errors++;
            $display("FAIL pre_rst got=%b/%b/%h need=1/1/0012", bus_ack, irq, bus_rdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus_ack !== 1'b0 || irq !== 1'b0 || bdrx_valid !== 2'b00 || bdrx_mf !== '0) begin
            errors++;
            $display("FAIL async_rst got=%b/%b/%b/%h need=0/0/00/0",
                     bus_ack, irq, bdrx_valid, bdrx_mf);
        end
        bus_cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        adr_q.push_back(ad(1, 6)); exp_q.push_back(16'h0000);
        adr_q.push_back(ad(1, 1)); exp_q.push_back(16'h0000);
        adr_q.push_back(ad(1, 4)); exp_q.push_back(16'h0000);
        adr_q.push_back(ad(1, 0)); exp_q.push_back(16'h0500);
        while (adr_q.size() > 0) begin
            bus_read(adr_q.pop_front(), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL post_rst got=%h need=%h", rd, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 10; i < 14; i++) bus_write(ad(1, 1), 16'(i));
        repeat (4) pulse(2'b10, 2'b00, 2'b00, 2'b00, 4'b0);
        bus_write(ad(1, 1), 16'd14);
        pulse(2'b10, 2'b00, 2'b00, 2'b00, 4'b0);
        adr_q.push_back(ad(1, 0)); exp_q.push_back(16'h1900);
        adr_q.push_back(ad(1, 6)); exp_q.push_back(16'h0040);
        adr_q.push_back(ad(1, 5)); exp_q.push_back(16'h0005);
        for (int i = 10; i < 14; i++) begin
            adr_q.push_back(ad(1, 1)); exp_q.push_back(16'h8000 | 16'(i));
        end
        adr_q.push_back(ad(1, 1)); exp_q.push_back(16'h0000);
        while (adr_q.size() > 0) begin
            bus_read(adr_q.pop_front(), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                errors++; $display("FAIL overflow got=%h need=%h", rd, exp);
            end
        end
    endtask

    task automatic test_csr();
        rx_aligned = 2'b10;
        bus_write(ad(1, 0), 16'h0005);
        checks++;
        if (rx_enable !== 2'b10 || rx_mode !== 4'b1000) begin
            errors++; $display("FAIL rx_ctl got=%b/%b need=10/1000", rx_enable, rx_mode);
        end
        bus_read(ad(1, 0), rd);
        checks++;
        if (rd !== 16'h1503) begin
            errors++; $display("FAIL r0_status got=%h need=1503", rd);
        end
        bus_write(ad(1, 0), 16'h1005);
        bus_read(ad(1, 0), rd);
        checks++;
        if (rd !== 16'h0503) begin
            errors++; $display("FAIL r0_clear got=%h need=0503", rd);
        end
        bus_write(ad(1, 2), 16'h0039);
        checks++;
        if ({tx_enable, tx_time_src, tx_alarm, tx_loopback, tx_mode} !== 12'b10101010_0000) begin
            errors++;
            $display("FAIL tx_ctl got=%b%b%b%b/%b need=10101010/0000",
                     tx_enable, tx_time_src, tx_alarm, tx_loopback, tx_mode);
        end
        bus_read(ad(1, 2), rd);
        checks++;
        if (rd !== 16'h0501) begin
            errors++; $display("FAIL r2_status got=%h need=0501", rd);
        end
    endtask

    initial begin
        test_reset();
        test_rx_fifo();
        test_miss();
        test_ebit();
        test_irq();
        test_reset_mid();
        test_back_to_back();
        test_csr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
